// File: rtl/dds_cfg_loader_if.sv
// Serial config link into the DDS loader plus the register/status bundle it drives.
// master = host/serial side, slave = loader side.
interface dds_cfg_loader_if #(
  parameter int TUNE_W  = 16,
  parameter int PHASE_W = 14
);
  logic               cs_n;
  logic               sclk;
  logic               sdata;
  logic [TUNE_W-1:0]  tune_word;
  logic [PHASE_W-1:0] phase_off;
  logic               out_en;
  logic [1:0]         wave_sel;
  logic               cfg_stb;
  logic               frame_err;
  logic               busy;

  modport master (
    output cs_n, sclk, sdata,
    input  tune_word, phase_off, out_en, wave_sel, cfg_stb, frame_err, busy
  );

  modport slave (
    input  cs_n, sclk, sdata,
    output tune_word, phase_off, out_en, wave_sel, cfg_stb, frame_err, busy
  );
endinterface

// File: rtl/dds_cfg_loader.sv
// Serial {addr,data} frame loader for the DDS tuning/phase/control registers.
// cs_n pin rise to register update and cfg_stb is SYNC_STAGES+2 clk edges; no backpressure.
module dds_cfg_loader #(
  parameter int TUNE_W      = 16,
  parameter int PHASE_W     = 14,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst_n,
  input logic         ena,
  dds_cfg_loader_if.slave cfg
);
  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic cs_prev_q, cs_prev_d, sclk_prev_q, sclk_prev_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TUNE_W-1:0]  tune_word_q, tune_word_d;
  logic [PHASE_W-1:0] phase_off_q, phase_off_d;
  logic               out_en_q, out_en_d;
  logic [1:0]         wave_sel_q, wave_sel_d;
  logic               cfg_stb_q, cfg_stb_d;
  logic               frame_err_q, frame_err_d;

  logic cs_s, sclk_s, sd_s;
  logic cs_fall, cs_rise, sclk_rise;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic frame_ok;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sd_s      = sd_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;

  assign frame_addr = shift_q[FRAME_W-1 -: ADDR_W];
  assign frame_data = shift_q[DATA_W-1:0];
  assign frame_ok   = (cnt_q == CNT_FULL) && (frame_addr < ADDR_W'(3));

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cfg.cs_n};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], cfg.sclk};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], cfg.sdata};
    cs_prev_d   = cs_s;
    sclk_prev_d = sclk_s;
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    tune_word_d = tune_word_q;
    phase_off_d = phase_off_q;
    out_en_d    = out_en_q;
    wave_sel_d  = wave_sel_q;
    cfg_stb_d   = 1'b0;
    frame_err_d = frame_err_q;

    case (state_q)
      IDLE: begin
        // Only a falling edge starts a frame, so a cs_n already low is ignored.
        if (ena && cs_fall) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (!ena) begin
          state_d = IDLE;
        end else if (cs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_W-2:0], sd_s};
          if (cnt_q != CNT_OVF) cnt_d = cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (frame_ok) begin
          if (frame_addr == ADDR_W'(0)) begin
            tune_word_d = frame_data[TUNE_W-1:0];
          end else if (frame_addr == ADDR_W'(1)) begin
            phase_off_d = frame_data[PHASE_W-1:0];
          end else begin
            out_en_d   = frame_data[0];
            wave_sel_d = frame_data[2:1];
          end
          cfg_stb_d   = 1'b1;
          frame_err_d = 1'b0;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Synchronisers reset low so a cs_n held low through reset never looks like a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      sd_sync_q   <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      tune_word_q <= '0;
      phase_off_q <= '0;
      out_en_q    <= 1'b0;
      wave_sel_q  <= 2'b00;
      cfg_stb_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      sd_sync_q   <= sd_sync_d;
      cs_prev_q   <= cs_prev_d;
      sclk_prev_q <= sclk_prev_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      tune_word_q <= tune_word_d;
      phase_off_q <= phase_off_d;
      out_en_q    <= out_en_d;
      wave_sel_q  <= wave_sel_d;
      cfg_stb_q   <= cfg_stb_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign cfg.tune_word = tune_word_q;
  assign cfg.phase_off = phase_off_q;
  assign cfg.out_en    = out_en_q;
  assign cfg.wave_sel  = wave_sel_q;
  assign cfg.cfg_stb   = cfg_stb_q;
  assign cfg.frame_err = frame_err_q;
  assign cfg.busy      = (state_q == SHIFT);
endmodule
